// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 Set-2 scan-code decoder.
// PS2_ASCII_LUT_EN adds an ascii field to key_event_t and the scan-to-ASCII table.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT      = 8'hE0;
    localparam logic [7:0] PS2_BRK      = 8'hF0;
    localparam logic [7:0] PS2_ERR0     = 8'h00;
    localparam logic [7:0] PS2_ERRF     = 8'hFF;
    localparam logic [7:0] PS2_BAT      = 8'hAA;
    localparam logic [7:0] PS2_ECHO     = 8'hEE;
    localparam logic [7:0] PS2_ACK      = 8'hFA;
    localparam logic [7:0] PS2_BAT_FAIL = 8'hFC;
    localparam logic [7:0] PS2_RESEND   = 8'hFE;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXT,
        S_BRK,
        S_EXT_BRK
    } dec_state_t;

    typedef struct packed {
        logic       ext;
        logic       rel;
        logic [7:0] code;
`ifdef PS2_ASCII_LUT_EN
        logic [7:0] ascii;
`endif
    } key_event_t;

    // Keyboard-to-host housekeeping replies; never turned into key events.
    function automatic logic is_ctrl_byte(input logic [7:0] b);
        return (b == PS2_BAT) || (b == PS2_ECHO) || (b == PS2_ACK) ||
               (b == PS2_BAT_FAIL) || (b == PS2_RESEND);
    endfunction

`ifdef PS2_ASCII_LUT_EN
    function automatic logic [7:0] scan_to_ascii(input logic [7:0] sc, input logic shift);
        logic [7:0] c;
        c = 8'h00;
        case (sc)
            8'h1C: c = "a";  8'h32: c = "b";  8'h21: c = "c";  8'h23: c = "d";
            8'h24: c = "e";  8'h2B: c = "f";  8'h34: c = "g";  8'h33: c = "h";
            8'h43: c = "i";  8'h3B: c = "j";  8'h42: c = "k";  8'h4B: c = "l";
            8'h3A: c = "m";  8'h31: c = "n";  8'h44: c = "o";  8'h4D: c = "p";
            8'h15: c = "q";  8'h2D: c = "r";  8'h1B: c = "s";  8'h2C: c = "t";
            8'h3C: c = "u";  8'h2A: c = "v";  8'h1D: c = "w";  8'h22: c = "x";
            8'h35: c = "y";  8'h1A: c = "z";
            8'h16: c = shift ? "!" : "1";
            8'h1E: c = shift ? "@" : "2";
            8'h26: c = shift ? "#" : "3";
            8'h25: c = shift ? "$" : "4";
            8'h2E: c = shift ? "%" : "5";
            8'h36: c = shift ? "^" : "6";
            8'h3D: c = shift ? "&" : "7";
            8'h3E: c = shift ? "*" : "8";
            8'h46: c = shift ? "(" : "9";
            8'h45: c = shift ? ")" : "0";
            8'h29: c = 8'h20;
            8'h5A: c = 8'h0D;
            8'h66: c = 8'h08;
            default: c = 8'h00;
        endcase
        if (shift && c >= "a" && c <= "z")
            c = c - 8'd32;
        return c;
    endfunction
`endif

endpackage

// File: rtl/ps2_event_fifo.sv
// First-word-fall-through event FIFO; a push into a full FIFO is dropped
// unless a pop frees the slot in the same cycle.
module ps2_event_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         push,
    input  logic [WIDTH-1:0]             din,
    input  logic                         pop,
    output logic [WIDTH-1:0]             dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         drop
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign drop    = push && full && !do_pop;

    // Zero head when empty so the event outputs read 0 out of reset.
    assign dout = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// Set-2 scan-byte to key-event decoder with repeat filter and event FIFO.
// PS2_ASCII_LUT_EN enables shift tracking and ASCII translation of each event.
//
// state      | meaning
// S_IDLE     | no prefix pending
// S_EXT      | E0 seen, waiting for code or F0
// S_BRK      | F0 seen, waiting for code
// S_EXT_BRK  | E0 F0 seen, waiting for code
module ps2_scancode_decoder
    import ps2_pkg::*;
#(
    parameter int DEPTH          = 8,
    parameter int TIMEOUT_CYCLES = 500000,
    parameter int FILTER_REPEAT  = 1
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         code_valid,
    input  logic [7:0]                   code,
    output logic                         ev_valid,
    input  logic                         ev_ready,
    output logic [7:0]                   ev_code,
    output logic                         ev_ext,
    output logic                         ev_rel,
    output logic [7:0]                   ev_ascii,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
    output logic                         overflow,
    input  logic                         ovf_clr,
    output logic                         err_pulse
);
    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES+1) : 1;
    localparam int EW = $bits(key_event_t);

    dec_state_t  state, state_nxt;
    logic [TW-1:0] tmr;
    logic        timeout;
    logic        emit, e_ext, e_rel, err_evt;
    logic        hv, hext;
    logic [7:0]  hcode;
    logic        held_match, suppress, push;
    logic        fifo_empty, fifo_full, fifo_drop, pop;
    key_event_t  ev_in, ev_out;
    logic [EW-1:0] fifo_dout;

    // Down-counter loaded with the full window; terminal count 1 marks the
    // last allowed idle cycle of a pending prefix.
    assign timeout = (TIMEOUT_CYCLES != 0) && (state != S_IDLE) && !code_valid &&
                     (tmr == TW'(1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            tmr   <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE || code_valid || timeout)
                tmr <= TW'(TIMEOUT_CYCLES);
            else
                tmr <= tmr - TW'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        emit      = 1'b0;
        e_ext     = 1'b0;
        e_rel     = 1'b0;
        err_evt   = 1'b0;
        if (timeout) begin
            err_evt   = 1'b1;
            state_nxt = S_IDLE;
        end else if (code_valid) begin
            case (state)
                S_IDLE: begin
                    if (code == PS2_EXT)
                        state_nxt = S_EXT;
                    else if (code == PS2_BRK)
                        state_nxt = S_BRK;
                    else if (code == PS2_ERR0 || code == PS2_ERRF)
                        err_evt = 1'b1;
                    else if (!is_ctrl_byte(code))
                        emit = 1'b1;
                end
                S_EXT: begin
                    if (code == PS2_BRK)
                        state_nxt = S_EXT_BRK;
                    else if (code != PS2_EXT) begin
                        emit      = 1'b1;
                        e_ext     = 1'b1;
                        state_nxt = S_IDLE;
                    end
                end
                S_BRK: begin
                    if (code == PS2_EXT) begin
                        err_evt   = 1'b1;
                        state_nxt = S_IDLE;
                    end else if (code != PS2_BRK) begin
                        emit      = 1'b1;
                        e_rel     = 1'b1;
                        state_nxt = S_IDLE;
                    end
                end
                S_EXT_BRK: begin
                    state_nxt = S_IDLE;
                    if (code == PS2_EXT || code == PS2_BRK)
                        err_evt = 1'b1;
                    else begin
                        emit  = 1'b1;
                        e_ext = 1'b1;
                        e_rel = 1'b1;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    assign err_pulse = err_evt;

    assign held_match = hv && (hext == e_ext) && (hcode == code);
    assign suppress   = (FILTER_REPEAT != 0) && emit && !e_rel && held_match;
    assign push       = emit && !suppress;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hv    <= 1'b0;
            hext  <= 1'b0;
            hcode <= 8'h00;
        end else if ((FILTER_REPEAT != 0) && emit) begin
            if (!e_rel) begin
                hv    <= 1'b1;
                hext  <= e_ext;
                hcode <= code;
            end else if (held_match) begin
                hv <= 1'b0;
            end
        end
    end

`ifdef PS2_ASCII_LUT_EN
    logic shift_l, shift_r;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shift_l <= 1'b0;
            shift_r <= 1'b0;
        end else if (emit && !e_ext) begin
            if (code == 8'h12) shift_l <= !e_rel;
            if (code == 8'h59) shift_r <= !e_rel;
        end
    end
`endif

    always_comb begin
        ev_in      = '0;
        ev_in.ext  = e_ext;
        ev_in.rel  = e_rel;
        ev_in.code = code;
`ifdef PS2_ASCII_LUT_EN
        ev_in.ascii = e_ext ? 8'h00 : scan_to_ascii(code, shift_l | shift_r);
`endif
    end

    assign pop = ev_valid && ev_ready;

    ps2_event_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (push),
        .din     (ev_in),
        .pop     (pop),
        .dout    (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count),
        .drop    (fifo_drop)
    );

    assign ev_out   = key_event_t'(fifo_dout);
    assign ev_valid = !fifo_empty;
    assign ev_code  = ev_out.code;
    assign ev_ext   = ev_out.ext;
    assign ev_rel   = ev_out.rel;
`ifdef PS2_ASCII_LUT_EN
    assign ev_ascii = ev_out.ascii;
`else
    assign ev_ascii = 8'h00;
`endif

    // A drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            overflow <= 1'b0;
        else if (fifo_drop)
            overflow <= 1'b1;
        else if (ovf_clr)
            overflow <= 1'b0;
    end

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed plus randomized bench for ps2_scancode_decoder against a
// prefix-flag / event-queue reference model.
module tb_ps2_scancode_decoder;
    localparam int DEPTH = 4;
    localparam int TMO   = 20;
    localparam int CW    = $clog2(DEPTH+1);

    logic          clock, reset_n;
    logic          code_valid;
    logic [7:0]    code;
    logic          ev_valid, ev_ready;
    logic [7:0]    ev_code, ev_ascii;
    logic          ev_ext, ev_rel;
    logic [CW-1:0] fifo_count;
    logic          overflow, ovf_clr, err_pulse;

    ps2_scancode_decoder #(
        .DEPTH          (DEPTH),
        .TIMEOUT_CYCLES (TMO),
        .FILTER_REPEAT  (1)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .code_valid (code_valid),
        .code       (code),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_code    (ev_code),
        .ev_ext     (ev_ext),
        .ev_rel     (ev_rel),
        .ev_ascii   (ev_ascii),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr),
        .err_pulse  (err_pulse)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model state
    logic [9:0] q[$];
    bit         pend_ext, pend_brk, m_ovf;
    int         quiet, held;
    int         nvec, nerr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        pend_ext = 0;
        pend_brk = 0;
        m_ovf    = 0;
        quiet    = 0;
        held     = -1;
    endtask

    task automatic check_outputs();
        chk("ev_valid", ev_valid, q.size() != 0);
        chk("fifo_count", fifo_count, q.size());
        chk("overflow", overflow, m_ovf);
        chk("ev_ascii", ev_ascii, 0);
        if (q.size() != 0) begin
            chk("ev_code", ev_code, q[0][7:0]);
            chk("ev_ext", ev_ext, q[0][9]);
            chk("ev_rel", ev_rel, q[0][8]);
        end else begin
            chk("ev_idle", {ev_ext, ev_rel, ev_code}, 0);
        end
    endtask

    // One clock: drive at negedge, check err_pulse mid-cycle, advance model at posedge.
    task automatic step(input bit v, input logic [7:0] b, input bit rdy, input bit clr);
        bit err_e, ev_e, ext_e, rel_e, popping;
        int key;
        code_valid = v;
        code       = b;
        ev_ready   = rdy;
        ovf_clr    = clr;
        #1;
        err_e = 0;
        ev_e  = 0;
        ext_e = pend_ext;
        rel_e = pend_brk;
        if (!v) begin
            if (pend_ext || pend_brk) begin
                quiet++;
                if (quiet == TMO) begin
                    err_e = 1; pend_ext = 0; pend_brk = 0; quiet = 0;
                end
            end else quiet = 0;
        end else begin
            quiet = 0;
            if (b == 8'hF0) begin
                if (pend_ext && pend_brk) begin
                    err_e = 1; pend_ext = 0; pend_brk = 0;
                end else pend_brk = 1;
            end else if (b == 8'hE0) begin
                if (pend_brk) begin
                    err_e = 1; pend_ext = 0; pend_brk = 0;
                end else pend_ext = 1;
            end else if (pend_ext || pend_brk) begin
                ev_e = 1; pend_ext = 0; pend_brk = 0;
            end else if (b == 8'h00 || b == 8'hFF) begin
                err_e = 1;
            end else if (!(b inside {8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE})) begin
                ev_e = 1;
            end
        end
        chk("err_pulse", err_pulse, err_e);
        if (ev_e) begin
            key = int'(ext_e) * 256 + int'(b);
            if (!rel_e) begin
                if (held == key) ev_e = 0;
                else held = key;
            end else if (held == key) begin
                held = -1;
            end
        end
        popping = rdy && (q.size() != 0);
        @(posedge clock);
        if (popping) void'(q.pop_front());
        if (ev_e && q.size() >= DEPTH) m_ovf = 1;
        else if (clr) m_ovf = 0;
        if (ev_e && q.size() < DEPTH) q.push_back({ext_e, rel_e, b});
        @(negedge clock);
        check_outputs();
    endtask

    logic [7:0] pool [12];

    initial begin
        nvec = 0;
        nerr = 0;
        model_reset();
        pool = '{8'hE0, 8'hF0, 8'h1C, 8'h32, 8'h75, 8'h29,
                 8'h12, 8'h59, 8'h00, 8'hFF, 8'hAA, 8'hFA};
        reset_n = 0; code_valid = 0; code = 0; ev_ready = 0; ovf_clr = 0;
        repeat (3) @(negedge clock);
        check_outputs();
        chk("err_reset", err_pulse, 0);
        reset_n = 1;

        // make + break
        step(1, 8'h1C, 0, 0); step(1, 8'hF0, 0, 0); step(1, 8'h1C, 0, 0);
        chk("mk_brk_count", fifo_count, 2);
        repeat (3) step(0, 8'h00, 1, 0);

        // extended make + break
        step(1, 8'hE0, 0, 0); step(1, 8'h75, 0, 0);
        step(1, 8'hE0, 0, 0); step(1, 8'hF0, 0, 0); step(1, 8'h75, 0, 0);
        chk("ext_count", fifo_count, 2);
        repeat (3) step(0, 8'h00, 1, 0);

        // typematic repeats
        step(1, 8'h1C, 0, 0); step(1, 8'h1C, 0, 0); step(1, 8'h1C, 0, 0);
        step(1, 8'hF0, 0, 0); step(1, 8'h1C, 0, 0);
        chk("filter_count", fifo_count, 2);
        repeat (3) step(0, 8'h00, 1, 0);

        // prefix timeout, then a normal make
        step(1, 8'hE0, 0, 0);
        repeat (TMO + 2) step(0, 8'h00, 0, 0);
        step(1, 8'h29, 0, 0);
        chk("tmo_then_make", {ev_valid, ev_ext, ev_rel, ev_code}, {1'b1, 2'b00, 8'h29});
        repeat (2) step(0, 8'h00, 1, 0);

        // overflow with DEPTH+1 distinct makes, then drain in order
        step(1, 8'h15, 0, 0); step(1, 8'h1D, 0, 0); step(1, 8'h24, 0, 0);
        step(1, 8'h2D, 0, 0); step(1, 8'h2C, 0, 0);
        chk("ovf_count", fifo_count, DEPTH);
        chk("ovf_flag", overflow, 1);
        chk("ovf_head", ev_code, 8'h15);
        repeat (DEPTH + 1) step(0, 8'h00, 1, 0);
        step(0, 8'h00, 0, 1);
        chk("ovf_cleared", overflow, 0);

        // break then E0 is an error
        step(1, 8'hF0, 0, 0); step(1, 8'hE0, 0, 0);

        // reset in the middle of E0 F0 with an event queued
        step(1, 8'h32, 0, 0); step(1, 8'hE0, 0, 0); step(1, 8'hF0, 0, 0);
        reset_n = 0;
        #1;
        chk("rst_valid", ev_valid, 0);
        chk("rst_count", fifo_count, 0);
        model_reset();
        code_valid = 0; ev_ready = 0; ovf_clr = 0;
        @(negedge clock);
        reset_n = 1;
        step(1, 8'h75, 0, 0);
        chk("post_rst_plain", {ev_ext, ev_rel, ev_code}, {2'b00, 8'h75});
        step(0, 8'h00, 1, 0);

        // randomized traffic with alternating consumer pressure
        for (int i = 0; i < 1500; i++) begin
            bit v, rdy, clr;
            v   = ($urandom_range(0, 2) != 0);
            rdy = ((i / 64) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0);
            clr = ($urandom_range(0, 15) == 0);
            step(v, pool[$urandom_range(0, 11)], rdy, clr);
            if ($urandom_range(0, 59) == 0)
                repeat (TMO + 3) step(0, 8'h00, $urandom_range(0, 1) == 1, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
